// File: rtl/naughty_q_core.sv
// Slot-addressed queue engine: DEPTH entries with valid flags, one command at a time
// over an enable/ready handshake, with per-command error and a sticky crash flag.
module naughty_q_core #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              ready,
  output logic              crashed,
  input  logic [3:0]        command,
  input  logic [IDX_W-1:0]  idx_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [IDX_W-1:0]  idx_out,
  output logic [DATA_W-1:0] data_out,
  output logic              error
);
  // state | meaning
  // IDLE  | ready, waiting for an accepted command
  // EXEC  | single-cycle command completing on the next edge
  // SCAN  | FIND walking slots; compare result registered one cycle behind scan_idx
  // DEAD  | illegal opcode seen, stuck until reset
  typedef enum logic [1:0] {IDLE, EXEC, SCAN, DEAD} state_t;

  localparam logic [3:0] OP_ENLIST = 4'd0;
  localparam logic [3:0] OP_READ   = 4'd1;
  localparam logic [3:0] OP_WRITE  = 4'd2;
  localparam logic [3:0] OP_UNLIST = 4'd3;
  localparam logic [3:0] OP_FIND   = 4'd4;
  localparam logic [3:0] OP_SIZE   = 4'd5;
  localparam logic [3:0] OP_CLEAR  = 4'd6;
  localparam logic [IDX_W:0]   FULL_CNT = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH-1);

  state_t              state, state_nxt;
  logic [3:0]          op_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]    valid;
  logic [IDX_W:0]      count;
  logic [IDX_W-1:0]    scan_idx, match_idx_q, free_idx;
  logic                tested_q, match_q;
  logic                accept, full, scan_done;
  logic                mem_we;
  logic [IDX_W-1:0]    mem_wa;

  assign ready     = (state == IDLE);
  assign accept    = ready && enable && !crashed;
  assign full      = (count == FULL_CNT);
  assign scan_done = tested_q && (match_q || match_idx_q == LAST_IDX);

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!valid[i]) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (command == OP_FIND) ? SCAN : EXEC;
      EXEC: state_nxt = (op_q > OP_CLEAR) ? DEAD : IDLE;
      SCAN: if (scan_done) state_nxt = IDLE;
      DEAD: state_nxt = DEAD;
      default: state_nxt = IDLE;
    endcase
  end

  // Storage is not reset; writes are blocked while reset is high so aborts leave no trace.
  assign mem_we = !reset && (state == EXEC) &&
                  ((op_q == OP_ENLIST && !full) || (op_q == OP_WRITE && valid[idx_q]));
  assign mem_wa = (op_q == OP_ENLIST) ? free_idx : idx_q;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      valid       <= '0;
      count       <= '0;
      crashed     <= 1'b0;
      error       <= 1'b0;
      idx_out     <= '0;
      data_out    <= '0;
      scan_idx    <= '0;
      tested_q    <= 1'b0;
      match_q     <= 1'b0;
      match_idx_q <= '0;
      op_q        <= '0;
      idx_q       <= '0;
      data_q      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q     <= command;
        idx_q    <= idx_in;
        data_q   <= data_in;
        error    <= 1'b0;
        scan_idx <= '0;
        tested_q <= 1'b0;
        match_q  <= 1'b0;
      end
      if (state == EXEC) begin
        case (op_q)
          OP_ENLIST: begin
            if (full) begin
              error   <= 1'b1;
              idx_out <= '0;
            end else begin
              valid[free_idx] <= 1'b1;
              count           <= count + 1'b1;
              idx_out         <= free_idx;
            end
          end
          OP_READ: begin
            idx_out <= idx_q;
            if (valid[idx_q]) data_out <= mem[idx_q];
            else begin
              error    <= 1'b1;
              data_out <= '0;
            end
          end
          OP_WRITE:  if (!valid[idx_q]) error <= 1'b1;
          OP_UNLIST: begin
            if (valid[idx_q]) begin
              valid[idx_q] <= 1'b0;
              count        <= count - 1'b1;
              data_out     <= mem[idx_q];
            end else error <= 1'b1;
          end
          OP_SIZE:  data_out <= DATA_W'(count);
          OP_CLEAR: begin
            valid <= '0;
            count <= '0;
          end
          default: crashed <= 1'b1;
        endcase
      end
      if (state == SCAN) begin
        tested_q    <= 1'b1;
        match_q     <= valid[scan_idx] && (mem[scan_idx] == data_q);
        match_idx_q <= scan_idx;
        scan_idx    <= scan_idx + 1'b1;
        if (scan_done) begin
          if (match_q) begin
            idx_out  <= match_idx_q;
            data_out <= data_q;
          end else begin
            error   <= 1'b1;
            idx_out <= '0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_naughty_q_core.sv
// Scoreboard bench for naughty_q_core: driver pushes expected results, a monitor
// pops and compares on each ready rise, including strobe-to-ready latency.
module tb_naughty_q_core;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       ready, crashed, error;
  logic [3:0] command = '0;
  logic [3:0] idx_in = '0;
  logic [7:0] data_in = '0;
  logic [3:0] idx_out;
  logic [7:0] data_out;

  naughty_q_core #(.DEPTH(16), .IDX_W(4), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .ready(ready), .crashed(crashed),
    .command(command), .idx_in(idx_in), .data_in(data_in),
    .idx_out(idx_out), .data_out(data_out), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic       err;
    logic       chk_idx;
    logic [3:0] idx;
    logic       chk_data;
    logic [7:0] data;
    int         lat;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, acc_cyc = 0;
  bit   pending = 1'b0;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) pending = 1'b0;
      else if (enable && ready && !crashed) begin
        pending = 1'b1;
        acc_cyc = cyc;
      end
      @(negedge clk);
      if (pending && ready && !reset) begin
        pending = 1'b0;
        if (q.size() == 0) chk("unexpected completion", 1, 0);
        else begin
          e = q.pop_front();
          chk({e.nm, " err"}, int'(error), int'(e.err));
          if (e.chk_idx)  chk({e.nm, " idx"}, int'(idx_out), int'(e.idx));
          if (e.chk_data) chk({e.nm, " data"}, int'(data_out), int'(e.data));
          chk({e.nm, " latency"}, cyc - acc_cyc, e.lat);
        end
      end
    end
  end

  task automatic do_cmd(input string nm, input logic [3:0] c, input logic [3:0] i,
                        input logic [7:0] d, input logic e_err, input logic ci,
                        input logic [3:0] ei, input logic cd, input logic [7:0] ed,
                        input int lat);
    exp_t e;
    e.nm = nm; e.err = e_err; e.chk_idx = ci; e.idx = ei;
    e.chk_data = cd; e.data = ed; e.lat = lat;
    q.push_back(e);
    command = c; idx_in = i; data_in = d; enable = 1'b1;
    @(posedge clk);
    #1 enable = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      #1;
      if (!pending) break;
    end
    if (pending) chk({nm, " completion timeout"}, 1, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset ready", ready, 1);
    chk("reset crashed", crashed, 0);
    chk("reset error", error, 0);
    chk("reset idx_out", idx_out, 0);
    chk("reset data_out", data_out, 0);

    do_cmd("enlist a1", 4'd0, 4'd0, 8'hA1, 0, 1, 4'd0, 0, 8'h00, 1);
    do_cmd("enlist b2", 4'd0, 4'd0, 8'hB2, 0, 1, 4'd1, 0, 8'h00, 1);
    do_cmd("enlist c3", 4'd0, 4'd0, 8'hC3, 0, 1, 4'd2, 0, 8'h00, 1);
    do_cmd("size 3",    4'd5, 4'd0, 8'h00, 0, 0, 4'd0, 1, 8'h03, 1);
    do_cmd("unlist 1",  4'd3, 4'd1, 8'h00, 0, 0, 4'd0, 1, 8'hB2, 1);
    do_cmd("enlist d4", 4'd0, 4'd0, 8'hD4, 0, 1, 4'd1, 0, 8'h00, 1);
    do_cmd("read 1",    4'd1, 4'd1, 8'h00, 0, 1, 4'd1, 1, 8'hD4, 1);
    do_cmd("read 5",    4'd1, 4'd5, 8'h00, 1, 1, 4'd5, 1, 8'h00, 1);

    for (int i = 3; i < 16; i++)
      do_cmd("fill", 4'd0, 4'd0, 8'(8'h40 + i), 0, 1, 4'(i), 0, 8'h00, 1);
    do_cmd("enlist full", 4'd0, 4'd0, 8'hEE, 1, 1, 4'd0, 0, 8'h00, 1);
    do_cmd("size 16",     4'd5, 4'd0, 8'h00, 0, 0, 4'd0, 1, 8'h10, 1);
    do_cmd("unlist 15",   4'd3, 4'd15, 8'h00, 0, 0, 4'd0, 1, 8'h4F, 1);
    do_cmd("unlist 15 again", 4'd3, 4'd15, 8'h00, 1, 0, 4'd0, 0, 8'h00, 1);
    do_cmd("size 15",     4'd5, 4'd0, 8'h00, 0, 0, 4'd0, 1, 8'h0F, 1);

    do_cmd("clear",       4'd6, 4'd0, 8'h00, 0, 0, 4'd0, 0, 8'h00, 1);
    do_cmd("size 0",      4'd5, 4'd0, 8'h00, 0, 0, 4'd0, 1, 8'h00, 1);
    do_cmd("enlist 11",   4'd0, 4'd0, 8'h11, 0, 1, 4'd0, 0, 8'h00, 1);
    do_cmd("enlist 22",   4'd0, 4'd0, 8'h22, 0, 1, 4'd1, 0, 8'h00, 1);
    do_cmd("enlist 33",   4'd0, 4'd0, 8'h33, 0, 1, 4'd2, 0, 8'h00, 1);
    do_cmd("find 33",     4'd4, 4'd0, 8'h33, 0, 1, 4'd2, 1, 8'h33, 4);
    do_cmd("find 99",     4'd4, 4'd0, 8'h99, 1, 1, 4'd0, 0, 8'h00, 17);
    do_cmd("write 1",     4'd2, 4'd1, 8'h55, 0, 0, 4'd0, 0, 8'h00, 1);
    do_cmd("find 55",     4'd4, 4'd0, 8'h55, 0, 1, 4'd1, 1, 8'h55, 3);
    do_cmd("write 9",     4'd2, 4'd9, 8'h66, 1, 0, 4'd0, 0, 8'h00, 1);
    do_cmd("read 1 after write", 4'd1, 4'd1, 8'h00, 0, 1, 4'd1, 1, 8'h55, 1);

    // Illegal opcode: no scoreboard entry, the engine must never complete.
    command = 4'd9; enable = 1'b1;
    @(posedge clk);
    #1 enable = 1'b0;
    chk("illegal accept ready", ready, 0);
    chk("illegal accept crashed", crashed, 0);
    @(posedge clk);
    #1;
    chk("crash set", crashed, 1);
    chk("crash ready", ready, 0);
    command = 4'd5; enable = 1'b1;
    repeat (3) @(posedge clk);
    #1 enable = 1'b0;
    chk("crash enable ignored", ready, 0);
    chk("crash sticky", crashed, 1);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("crash reset crashed", crashed, 0);
    chk("crash reset ready", ready, 1);
    do_cmd("size after crash", 4'd5, 4'd0, 8'h00, 0, 0, 4'd0, 1, 8'h00, 1);

    // Reset in the middle of a FIND scan.
    do_cmd("enlist 77", 4'd0, 4'd0, 8'h77, 0, 1, 4'd0, 0, 8'h00, 1);
    command = 4'd4; data_in = 8'h00; enable = 1'b1;
    @(posedge clk);
    #1 enable = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    chk("scan reset ready", ready, 1);
    chk("scan reset error", error, 0);
    reset = 1'b0;
    do_cmd("read 0 after reset", 4'd1, 4'd0, 8'h00, 1, 1, 4'd0, 1, 8'h00, 1);
    do_cmd("size after scan reset", 4'd5, 4'd0, 8'h00, 0, 0, 4'd0, 1, 8'h00, 1);

    repeat (2) @(posedge clk);
    chk("scoreboard drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
